// File: rtl/line_framer.sv
// line_framer: schedules one framed line (sync word, info word, LINE_WORDS
// pixel words, trailer) toward the downstream transfer FIFO. Pixel-buffer
// read latency is absorbed by an 8-entry skid FIFO throttled via PIX_HOLD.
module line_framer #(
   parameter int          LINE_WORDS = 1536,
   parameter logic [31:0] SYNC_WORD  = 32'hA5A5_5A5A
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LINE_START,
   input  logic [31:0] PIX_DIN,
   input  logic        PIX_DIN_DV,
   input  logic        PIX_OVRF,
   output logic        PIX_HOLD,
   output logic [31:0] DOUT,
   output logic        DOUT_DV,
   input  logic        AFULL,
   output logic [15:0] LINE_CNT,
   output logic        LINE_DROP,
   output logic        BUSY
);

   typedef enum logic [2:0] {IDLE, HSYNC, HINFO, DATA, TRAIL} state_t;

   localparam logic [15:0] LW16 = 16'(LINE_WORDS);

   state_t      state, state_nxt;

   logic [31:0] skid_mem [8];
   logic [2:0]  wr_ptr, rd_ptr;
   logic [3:0]  level;
   logic        skid_full, skid_empty;
   logic        push, drop_wr, pop;

   logic [15:0] word_cnt;
   logic [15:0] sum;
   logic        ovr;

   logic        sel_vld;
   logic [31:0] sel_word;
   logic        line_done;

   // Mod-2^16 checksum contribution of one packed pixel word.
   function automatic logic [15:0] add_pix(input logic [15:0] acc, input logic [31:0] w);
      return acc + w[31:16] + w[15:0];
   endfunction

   assign skid_full  = (level == 4'd8);
   assign skid_empty = (level == 4'd0);
   // A write into a full skid is dropped and leaves the FIFO untouched.
   assign push       = PIX_DIN_DV && !skid_full;
   assign drop_wr    = PIX_DIN_DV && skid_full;
   assign BUSY       = (state != IDLE);

   // Next-state and word selection for the output register.
   always_comb begin
      state_nxt = state;
      sel_vld   = 1'b0;
      sel_word  = '0;
      pop       = 1'b0;
      line_done = 1'b0;
      case (state)
         IDLE: begin
            if (LINE_START) state_nxt = HSYNC;
         end
         HSYNC: begin
            if (!AFULL) begin
               sel_vld   = 1'b1;
               sel_word  = SYNC_WORD;
               state_nxt = HINFO;
            end
         end
         HINFO: begin
            if (!AFULL) begin
               sel_vld   = 1'b1;
               sel_word  = {LINE_CNT, LW16};
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (!AFULL && !skid_empty) begin
               pop      = 1'b1;
               sel_vld  = 1'b1;
               sel_word = skid_mem[rd_ptr];
               if (word_cnt + 16'd1 == LW16) state_nxt = TRAIL;
            end
         end
         TRAIL: begin
            if (!AFULL) begin
               sel_vld   = 1'b1;
               sel_word  = {ovr, 15'd0, sum};
               line_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // Skid FIFO pointers and fill level; reset empties it.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 3'd1;
         if (pop)  rd_ptr <= rd_ptr + 3'd1;
         case ({push, pop})
            2'b10:   level <= level + 4'd1;
            2'b01:   level <= level - 4'd1;
            default: level <= level;
         endcase
      end
   end

   // Skid FIFO storage (data only, not reset).
   always_ff @(posedge CLK) begin
      if (push) skid_mem[wr_ptr] <= PIX_DIN;
   end

   // Per-line bookkeeping: word count, checksum, sticky overflow, line count.
   always_ff @(posedge CLK) begin
      if (RST) begin
         word_cnt <= '0;
         sum      <= '0;
         ovr      <= 1'b0;
         LINE_CNT <= '0;
      end else begin
         if (line_done) begin
            word_cnt <= '0;
            sum      <= '0;
            LINE_CNT <= LINE_CNT + 16'd1;
         end else if (pop) begin
            word_cnt <= word_cnt + 16'd1;
            sum      <= add_pix(sum, skid_mem[rd_ptr]);
         end
         // An overflow event in the trailer cycle is kept for the next line.
         ovr <= (ovr && !line_done) || PIX_OVRF || drop_wr;
      end
   end

   // Registered outputs: framed word, hold to the pixel buffer, drop pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DOUT      <= '0;
         DOUT_DV   <= 1'b0;
         PIX_HOLD  <= 1'b1;
         LINE_DROP <= 1'b0;
      end else begin
         if (sel_vld) DOUT <= sel_word;
         DOUT_DV   <= sel_vld;
         PIX_HOLD  <= (state != DATA) || AFULL || (level >= 4'd4);
         LINE_DROP <= LINE_START && (state != IDLE);
      end
   end

endmodule

// File: tb/tb_line_framer.sv
// Directed bench for line_framer with LINE_WORDS=4: cycle tables for the
// nominal, backpressure and idle-prefill/drop lines, plus hand sequences
// for overflow and mid-line reset.
module tb_line_framer;

   logic        CLK, RST, LINE_START, PIX_DIN_DV, PIX_OVRF, AFULL;
   logic [31:0] PIX_DIN, DOUT;
   logic        PIX_HOLD, DOUT_DV, LINE_DROP, BUSY;
   logic [15:0] LINE_CNT;

   int total = 0;
   int bad   = 0;

   localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

   line_framer #(.LINE_WORDS(4), .SYNC_WORD(SYNC)) dut (
      .CLK(CLK), .RST(RST), .LINE_START(LINE_START),
      .PIX_DIN(PIX_DIN), .PIX_DIN_DV(PIX_DIN_DV), .PIX_OVRF(PIX_OVRF),
      .PIX_HOLD(PIX_HOLD), .DOUT(DOUT), .DOUT_DV(DOUT_DV), .AFULL(AFULL),
      .LINE_CNT(LINE_CNT), .LINE_DROP(LINE_DROP), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        ls;
      logic [31:0] din;
      logic        dv;
      logic        af;
      logic        edv;
      logic [31:0] edout;
      logic        ehold;
      logic        ebusy;
      logic [15:0] ecnt;
      logic        edrop;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic ls, input logic [31:0] din, input logic dv, input logic af,
                      input logic edv, input logic [31:0] edout, input logic ehold,
                      input logic ebusy, input logic [15:0] ecnt, input logic edrop);
      vec_t v;
      v.ls = ls; v.din = din; v.dv = dv; v.af = af;
      v.edv = edv; v.edout = edout; v.ehold = ehold;
      v.ebusy = ebusy; v.ecnt = ecnt; v.edrop = edrop;
      tv.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      PIX_DIN    = w;
      PIX_DIN_DV = 1'b1;
      @(negedge CLK);
      PIX_DIN_DV = 1'b0;
      PIX_DIN    = '0;
   endtask

   // Pulses LINE_START, collects the 7 words of one line and compares them.
   task automatic run_line(input string name, input logic [31:0] exp [7], input int ovrf_at);
      logic [31:0] got [7];
      int n;
      n = 0;
      LINE_START = 1'b1;
      @(negedge CLK);
      LINE_START = 1'b0;
      for (int c = 0; c < 40 && n < 7; c++) begin
         if (DOUT_DV) begin
            got[n] = DOUT;
            n++;
         end
         PIX_OVRF = (c == ovrf_at);
         @(negedge CLK);
      end
      PIX_OVRF = 1'b0;
      if (n < 7) begin
         total++;
         bad++;
         $display("FAIL %s timeout words=%0d required=7", name, n);
      end else begin
         for (int i = 0; i < 7; i++) chk($sformatf("%s w%0d", name, i), got[i], exp[i]);
      end
      chk($sformatf("%s busy_after", name), {31'd0, BUSY}, 32'd0);
   endtask

   localparam logic [31:0] W1 = 32'h0010_0001, W2 = 32'h0020_0002,
                           W3 = 32'h0030_0003, W4 = 32'h0040_0004;
   localparam logic [31:0] P1 = 32'h0001_0000, P2 = 32'h0002_0000,
                           P3 = 32'h0003_0000, P4 = 32'h0004_0000;

   initial begin
      logic [31:0] e [7];

      // nominal line, words 1..4, checksum 0xA
      add(1, 1, 1, 0,  0, 32'h0,        1, 1, 0, 0);
      add(0, 2, 1, 0,  1, SYNC,         1, 1, 0, 0);
      add(0, 3, 1, 0,  1, 32'h00000004, 1, 1, 0, 0);
      add(0, 4, 1, 0,  1, 32'h1,        0, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'h2,        0, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'h3,        0, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'h4,        0, 1, 0, 0);
      add(0, 0, 0, 0,  1, 32'h0000000A, 1, 0, 1, 0);
      add(0, 0, 0, 0,  0, 32'h0000000A, 1, 0, 1, 0);
      // backpressure: AFULL high 5 cycles in DATA, checksum 0xAA
      add(1, W1, 1, 0, 0, 32'h0000000A, 1, 1, 1, 0);
      add(0, W2, 1, 0, 1, SYNC,         1, 1, 1, 0);
      add(0, 0,  0, 0, 1, 32'h00010004, 1, 1, 1, 0);
      add(0, 0,  0, 0, 1, W1,           0, 1, 1, 0);
      add(0, W3, 1, 1, 0, W1,           1, 1, 1, 0);
      add(0, 0,  0, 1, 0, W1,           1, 1, 1, 0);
      add(0, W4, 1, 1, 0, W1,           1, 1, 1, 0);
      add(0, 0,  0, 1, 0, W1,           1, 1, 1, 0);
      add(0, 0,  0, 1, 0, W1,           1, 1, 1, 0);
      add(0, 0,  0, 0, 1, W2,           0, 1, 1, 0);
      add(0, 0,  0, 0, 1, W3,           0, 1, 1, 0);
      add(0, 0,  0, 0, 1, W4,           0, 1, 1, 0);
      add(0, 0,  0, 0, 1, 32'h000000AA, 1, 0, 2, 0);
      // words arriving in IDLE, then LINE_START ignored during DATA
      add(0, P1, 1, 0, 0, 32'h000000AA, 1, 0, 2, 0);
      add(0, P2, 1, 0, 0, 32'h000000AA, 1, 0, 2, 0);
      add(0, P3, 1, 0, 0, 32'h000000AA, 1, 0, 2, 0);
      add(1, 0,  0, 0, 0, 32'h000000AA, 1, 1, 2, 0);
      add(0, 0,  0, 0, 1, SYNC,         1, 1, 2, 0);
      add(0, 0,  0, 0, 1, 32'h00020004, 1, 1, 2, 0);
      add(1, P4, 1, 0, 1, P1,           0, 1, 2, 1);
      add(0, 0,  0, 0, 1, P2,           0, 1, 2, 0);
      add(0, 0,  0, 0, 1, P3,           0, 1, 2, 0);
      add(0, 0,  0, 0, 1, P4,           0, 1, 2, 0);
      add(0, 0,  0, 0, 1, 32'h0000000A, 1, 0, 3, 0);
      add(0, 0,  0, 0, 0, 32'h0000000A, 1, 0, 3, 0);

      RST = 1'b1; LINE_START = 1'b0; PIX_DIN = '0; PIX_DIN_DV = 1'b0;
      PIX_OVRF = 1'b0; AFULL = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst dout",  DOUT, 32'h0);
      chk("rst dv",    {31'd0, DOUT_DV}, 32'd0);
      chk("rst hold",  {31'd0, PIX_HOLD}, 32'd1);
      chk("rst busy",  {31'd0, BUSY}, 32'd0);
      chk("rst cnt",   {16'd0, LINE_CNT}, 32'd0);
      chk("rst drop",  {31'd0, LINE_DROP}, 32'd0);
      RST = 1'b0;

      for (int i = 0; i < tv.size(); i++) begin
         LINE_START = tv[i].ls;
         PIX_DIN    = tv[i].din;
         PIX_DIN_DV = tv[i].dv;
         AFULL      = tv[i].af;
         @(negedge CLK);
         chk($sformatf("row%0d dv", i),   {31'd0, DOUT_DV},   {31'd0, tv[i].edv});
         chk($sformatf("row%0d dout", i), DOUT,               tv[i].edout);
         chk($sformatf("row%0d hold", i), {31'd0, PIX_HOLD},  {31'd0, tv[i].ehold});
         chk($sformatf("row%0d busy", i), {31'd0, BUSY},      {31'd0, tv[i].ebusy});
         chk($sformatf("row%0d cnt", i),  {16'd0, LINE_CNT},  {16'd0, tv[i].ecnt});
         chk($sformatf("row%0d drop", i), {31'd0, LINE_DROP}, {31'd0, tv[i].edrop});
      end
      LINE_START = 1'b0; PIX_DIN = '0; PIX_DIN_DV = 1'b0; AFULL = 1'b0;

      // PIX_OVRF pulse during DATA sets trailer bit 31
      for (int i = 1; i <= 4; i++) push_word({16'(i), 16'(i)});
      e = '{SYNC, 32'h00030004, 32'h00010001, 32'h00020002, 32'h00030003, 32'h00040004, 32'h80000014};
      run_line("ovrf", e, 3);

      // fill skid to 8 (Q5..Q12), 9th write Q13 is dropped and flags the line
      for (int i = 5; i <= 13; i++) push_word({16'(i), 16'(i)});
      e = '{SYNC, 32'h00040004, 32'h00050005, 32'h00060006, 32'h00070007, 32'h00080008, 32'h80000034};
      run_line("full", e, -1);

      // leftover Q9..Q12 form the next line; Q13 absent; flag cleared
      e = '{SYNC, 32'h00050004, 32'h00090009, 32'h000A000A, 32'h000B000B, 32'h000C000C, 32'h00000054};
      run_line("leftover", e, -1);

      // reset in the middle of DATA
      for (int i = 1; i <= 4; i++) push_word(32'hDEAD_0000 + 32'(i));
      LINE_START = 1'b1;
      @(negedge CLK);
      LINE_START = 1'b0;
      repeat (3) @(negedge CLK);
      chk("midrst pre dout", DOUT, 32'hDEAD_0001);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("midrst dv",   {31'd0, DOUT_DV}, 32'd0);
      chk("midrst dout", DOUT, 32'h0);
      chk("midrst hold", {31'd0, PIX_HOLD}, 32'd1);
      chk("midrst cnt",  {16'd0, LINE_CNT}, 32'd0);
      chk("midrst busy", {31'd0, BUSY}, 32'd0);
      @(negedge CLK);
      chk("midrst no trailer", {31'd0, DOUT_DV}, 32'd0);

      // skid was emptied: the next line carries only the new words, count 0
      for (int i = 1; i <= 4; i++) push_word({8'(i), 24'd0});
      e = '{SYNC, 32'h00000004, 32'h01000000, 32'h02000000, 32'h03000000, 32'h04000000, 32'h00000A00};
      run_line("postrst", e, -1);
      chk("postrst cnt", {16'd0, LINE_CNT}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_framer.md
# line_framer

Output scheduler between the pixel buffer and the downstream transfer FIFO. Per line it emits a two-word header, exactly `LINE_WORDS` packed pixel words, and a one-word trailer, in that order. It throttles the pixel buffer through `PIX_HOLD` and absorbs the buffer's read latency in an internal 8-entry skid FIFO. The downstream side is held off only by `AFULL`.

## Interface
- `LINE_WORDS`, 1536: 32-bit pixel words per line; range 1..65535.
- `SYNC_WORD`, 32'hA5A5_5A5A: first header word.
- `CLK` in 1: single clock for the whole block.
- `RST` in 1: reset; synchronous, active-high.
- `LINE_START` in 1: 1-cycle pulse that requests a new line.
- `PIX_DIN` in 32: packed pixel word from the pixel buffer.
- `PIX_DIN_DV` in 1: `PIX_DIN` valid.
- `PIX_OVRF` in 1: overflow pulse from the pixel buffer FIFOs.
- `PIX_HOLD` out 1: drives the pixel buffer `AFULL`; 1 = stop reading.
- `DOUT` out 32: framed output word.
- `DOUT_DV` out 1: `DOUT` valid.
- `AFULL` in 1: downstream almost-full; 1 = no new words may start.
- `LINE_CNT` out 16: count of completed lines.
- `LINE_DROP` out 1: 1-cycle pulse when a `LINE_START` is ignored.
- `BUSY` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, HSYNC, HINFO, DATA, TRAIL.
- IDLE -> HSYNC when `LINE_START`=1.
- HSYNC: when `AFULL`=0, emit `SYNC_WORD`, then go to HINFO.
- HINFO: when `AFULL`=0, emit {`LINE_CNT`, `LINE_WORDS`[15:0]}, then go to DATA.
- DATA: when `AFULL`=0 and the skid FIFO is non-empty, pop one word, emit it and increment `word_cnt`.
  - After the pop that makes `word_cnt`=`LINE_WORDS`, go to TRAIL.
- TRAIL: when `AFULL`=0, emit {`ovr`, 15'd0, `sum`}.
  - Same cycle: `LINE_CNT`+1 (wraps at 16 bits); clear `ovr`, `sum` and `word_cnt`; go to IDLE.
- `sum`: 16-bit mod-2^16 accumulation of `DOUT`[31:16]+`DOUT`[15:0] over the line's pixel words only.
- `ovr`: sticky flag. Set by either:
  - `PIX_OVRF`=1 in any state, or
  - a skid write while the skid FIFO holds 8 entries (the word is dropped, the FIFO is unchanged).
- Skid FIFO:
  - Accepts every `PIX_DIN_DV` word in any state.
  - Pops only in DATA.
  - Words left over after TRAIL belong to the next line; they are not flushed.
- `PIX_HOLD` is registered: next value = (state≠DATA) | `AFULL` | (skid level ≥ 4).
- `LINE_START` while `BUSY`=1: ignored, and `LINE_DROP` pulses the next cycle.
- Simultaneous skid write and pop: level unchanged; both words are handled correctly.
- Reset, including mid-line:
  - Return to IDLE; empty the skid FIFO.
  - `word_cnt`, `sum`, `ovr`, `LINE_CNT`=0.
  - `DOUT`=0, `DOUT_DV`=0, `LINE_DROP`=0, `BUSY`=0, `PIX_HOLD`=1.
  - No trailer is emitted for the aborted line.

## Timing
- `DOUT` and `DOUT_DV` are registered.
  - A word selected in cycle t appears with `DOUT_DV`=1 in t+1.
  - `DOUT` holds its value while `DOUT_DV`=0.
- `LINE_START` at cycle t in IDLE: HSYNC at t+1; `SYNC_WORD` valid at t+2 at the earliest.
- `AFULL` is sampled each cycle. `AFULL`=1 at t means no word is selected at t, so `DOUT_DV`=0 at t+1. The downstream FIFO must provide ≥ 1 word of margin after `AFULL`.
- Peak rate: 1 word/cycle. An uninterrupted line lasts `LINE_WORDS`+3 output cycles.
- Pixel buffer hold-to-stop latency is ≤ 3 cycles. With the hold threshold at level 4 and depth 8, no words are dropped under legal operation.
- `LINE_DROP` and `ovr` setting each take 1 cycle from the causing input.

## Test plan
- Nominal line, `LINE_WORDS`=4, `AFULL`=0, pixel words 1,2,3,4 streamed -> output A5A55A5A, 00000004, 1, 2, 3, 4, 0000000A on consecutive cycles; `LINE_CNT`=1.
- Backpressure: `AFULL` held high 5 cycles during DATA -> `DOUT_DV`=0 for exactly those cycles; `PIX_HOLD` rises 1 cycle after `AFULL`; no word lost or duplicated; trailer `ovr`=0.
- Pixel words arriving in IDLE (3 words) -> `PIX_HOLD` stays 1; next line's first 3 pixel words are those 3 words, in order.
- `LINE_START` pulsed during DATA -> `LINE_DROP` pulses once; current line completes unchanged; no extra header.
- `PIX_OVRF` pulse mid-line, then a 9th skid write while the FIFO is full -> trailer bit 31=1, dropped word absent; next trailer bit 31=0.
- `RST` asserted mid-DATA -> next cycle `DOUT_DV`=0, `PIX_HOLD`=1, `LINE_CNT`=0; a following `LINE_START` produces a header with `LINE_CNT` field 0.
